axi4s_bram_responder: RTL and testbench

//  AXI4 slave (responder) with a BRAM-backed word memory. It answers the AXI4 write master
//  (fifo_to_axi4m) and read master (axi4m_to_fifo) on the ui_clk domain. It stands in for
//  mig_7series_0 on boards or benches without DDR3, and also serves as on-chip scratch memory.

---
 rtl/axi4s_bram_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_axi4s_bram_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4s_bram_responder.sv
// rtl/axi4s_bram_responder.sv - AXI4 slave backed by a dual-port word BRAM, one burst in flight per direction
// Optional AXI_SLV_ERRCHK_EN: SLVERR on out-of-range bursts and misplaced wlast.
module axi4s_bram_responder #(
  parameter int C_S_AXI_ID_WIDTH   = 4,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH     = 12
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic [1:0]                      s_axi_awburst,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  input  logic [1:0]                      s_axi_arburst,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int MW    = MEM_ADDR_WIDTH;
  localparam int DEPTH = 1 << MW;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_e;
  typedef enum logic [1:0] {RIDLE, RFETCH, RDATA} rstate_e;

  wstate_e                     wstate_q;
  rstate_e                     rstate_q;
  logic                        awready_q, wready_q, bvalid_q;
  logic                        arready_q, rvalid_q, rlast_q;
  logic [C_S_AXI_ID_WIDTH-1:0] bid_q, rid_q;
  logic [1:0]                  bresp_q, rresp_q;
  logic [MW-1:0]               waddr_q, raddr_q;
  logic [7:0]                  wcnt_q, rcnt_q;
  logic                        wfixed_q, rfixed_q;
  logic                        waddr_err_q, wlast_err_q, rerr_q;
  logic [DW-1:0]               mem_rdata_q;
  logic [DW-1:0]               mem [DEPTH];

  logic          aw_hs, w_hs, ar_hs, r_hs, mem_we, mem_re;
  logic          aw_err, ar_err, wlast_bad;
  logic [MW-1:0] aw_word, ar_word;

  assign aw_hs   = s_axi_awvalid & awready_q;
  assign w_hs    = s_axi_wvalid & wready_q;
  assign ar_hs   = s_axi_arvalid & arready_q;
  assign r_hs    = rvalid_q & s_axi_rready;
  assign aw_word = s_axi_awaddr[MW+1:2];
  assign ar_word = s_axi_araddr[MW+1:2];
  assign mem_we  = w_hs & ~waddr_err_q;
  // Fetch the first word in RFETCH, then the next word on every accepted non-final beat.
  assign mem_re  = (rstate_q == RFETCH) | (r_hs & ~rlast_q);

`ifdef AXI_SLV_ERRCHK_EN
  assign aw_err = ((s_axi_awaddr >> (MW + 2)) != '0) ||
                  ((s_axi_awburst != BURST_FIXED) && ((32'(aw_word) + 32'(s_axi_awlen)) >= 32'(DEPTH)));
  assign ar_err = ((s_axi_araddr >> (MW + 2)) != '0) ||
                  ((s_axi_arburst != BURST_FIXED) && ((32'(ar_word) + 32'(s_axi_arlen)) >= 32'(DEPTH)));
  assign wlast_bad = s_axi_wlast != (wcnt_q == 8'd0);
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, s_axi_wlast,
                       s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:MW+2], s_axi_awaddr[1:0],
                       s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:MW+2], s_axi_araddr[1:0]};
  assign aw_err    = 1'b0;
  assign ar_err    = 1'b0;
  assign wlast_bad = 1'b0;
`endif

  // Port A writes, port B reads; same-edge access to one word returns the old contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < DW/8; b++)
        if (s_axi_wstrb[b]) mem[waddr_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_re) mem_rdata_q <= mem[raddr_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wstate_q    <= WIDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= RESP_OKAY;
      waddr_q     <= '0;
      wcnt_q      <= '0;
      wfixed_q    <= 1'b0;
      waddr_err_q <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      case (wstate_q)
        WIDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            awready_q   <= 1'b0;
            wready_q    <= 1'b1;
            bid_q       <= s_axi_awid;
            waddr_q     <= aw_word;
            wcnt_q      <= s_axi_awlen;
            wfixed_q    <= s_axi_awburst == BURST_FIXED;
            waddr_err_q <= aw_err;
            wlast_err_q <= 1'b0;
            wstate_q    <= WDATA;
          end
        end
        WDATA: begin
          if (w_hs) begin
            if (!wfixed_q) waddr_q <= waddr_q + 1'b1;
            if (wlast_bad) wlast_err_q <= 1'b1;
            if (wcnt_q == 8'd0) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (waddr_err_q | wlast_err_q | wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              wstate_q <= WRESP;
            end else begin
              wcnt_q <= wcnt_q - 8'd1;
            end
          end
        end
        default: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= WIDLE;
          end
        end
      endcase
    end
  end

  // rcnt_q holds the number of beats still to come after the one being presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rstate_q  <= RIDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
      raddr_q   <= '0;
      rcnt_q    <= '0;
      rfixed_q  <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      case (rstate_q)
        RIDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            rid_q     <= s_axi_arid;
            raddr_q   <= ar_word;
            rcnt_q    <= s_axi_arlen;
            rfixed_q  <= s_axi_arburst == BURST_FIXED;
            rerr_q    <= ar_err;
            rstate_q  <= RFETCH;
          end
        end
        RFETCH: begin
          if (!rfixed_q) raddr_q <= raddr_q + 1'b1;
          rvalid_q <= 1'b1;
          rlast_q  <= rcnt_q == 8'd0;
          rresp_q  <= rerr_q ? RESP_SLVERR : RESP_OKAY;
          rstate_q <= RDATA;
        end
        default: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= RIDLE;
            end else begin
              if (!rfixed_q) raddr_q <= raddr_q + 1'b1;
              rcnt_q  <= rcnt_q - 8'd1;
              rlast_q <= rcnt_q == 8'd1;
            end
          end
        end
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = !rvalid_q ? '0 : (rerr_q ? DW'(32'hDEADDEAD) : mem_rdata_q);
endmodule

// File: tb/tb_axi4s_bram_responder.sv
// tb/tb_axi4s_bram_responder.sv - scoreboard bench for axi4s_bram_responder
module tb_axi4s_bram_responder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  s_axi_awid = '0;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [1:0]  s_axi_awburst = 2'b01;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [3:0]  s_axi_arid = '0;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [1:0]  s_axi_arburst = 2'b01;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;

  axi4s_bram_responder #(
    .C_S_AXI_ID_WIDTH(4), .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .MEM_ADDR_WIDTH(12)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
    logic [1:0]  resp;
  } rexp_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] wbuf [256];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          rtoggle = 1'b0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endfunction

  function automatic void push_r(logic [3:0] id, logic [31:0] data, logic last, logic [1:0] resp);
    rexp_t e;
    e.id = id; e.data = data; e.last = last; e.resp = resp;
    rq.push_back(e);
  endfunction

  function automatic void push_b(logic [3:0] id, logic [1:0] resp);
    bexp_t e;
    e.id = id; e.resp = resp;
    bq.push_back(e);
  endfunction

  // rready either held high or toggled every cycle
  initial forever begin
    @(posedge clk); #1;
    s_axi_rready = rtoggle ? ~s_axi_rready : 1'b1;
  end

  // Monitor: pops the scoreboard on every R/B handshake and checks stall stability.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_rdata = '0;
  logic        prev_rlast = 1'b0;
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("r_stall_valid", {31'd0, s_axi_rvalid}, 32'd1);
      chk("r_stall_data", s_axi_rdata, prev_rdata);
      chk("r_stall_last", {31'd0, s_axi_rlast}, {31'd0, prev_rlast});
    end
    prev_stall = s_axi_rvalid && !s_axi_rready;
    prev_rdata = s_axi_rdata;
    prev_rlast = s_axi_rlast;
    if (reset_n && s_axi_rvalid && s_axi_rready) begin
      if (rq.size() == 0) begin
        n_checks++;
        $display("FAIL r_unexpected: got beat %h expected none", s_axi_rdata);
      end else begin
        rexp_t e;
        e = rq.pop_front();
        chk("rdata", s_axi_rdata, e.data);
        chk("rid", {28'd0, s_axi_rid}, {28'd0, e.id});
        chk("rlast", {31'd0, s_axi_rlast}, {31'd0, e.last});
        chk("rresp", {30'd0, s_axi_rresp}, {30'd0, e.resp});
      end
    end
    if (reset_n && s_axi_bvalid && s_axi_bready) begin
      if (bq.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected: got bid %h expected none", s_axi_bid);
      end else begin
        bexp_t e;
        e = bq.pop_front();
        chk("bid", {28'd0, s_axi_bid}, {28'd0, e.id});
        chk("bresp", {30'd0, s_axi_bresp}, {30'd0, e.resp});
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                          input logic [3:0] strb, input bit bad_wlast);
    int t;
    @(posedge clk); #1;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len[7:0];
    s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_axi_awready && t < 100);
    chk("aw_accept_in_time", {31'd0, s_axi_awready}, 32'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s_axi_wdata = wbuf[i]; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
      s_axi_wlast = bad_wlast ? (i == 0) : (i == len);
      t = 0;
      do begin @(negedge clk); t++; end while (!s_axi_wready && t < 100);
      chk("w_accept_in_time", {31'd0, s_axi_wready}, 32'd1);
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] id);
    int t;
    @(posedge clk); #1;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len[7:0];
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_axi_arready && t < 100);
    chk("ar_accept_in_time", {31'd0, s_axi_arready}, 32'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_axi_rvalid && t < 100);
    chk("r_first_latency", t, 32'd2);
    t = 0;
    while (!(s_axi_rvalid && s_axi_rready && s_axi_rlast) && t < 1000) begin
      @(negedge clk); t++;
    end
    chk("r_burst_done_in_time", {31'd0, t < 1000}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < 1000) begin
      @(negedge clk); t++;
    end
    chk("scoreboard_drained", {31'd0, t < 1000}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_awready", {31'd0, s_axi_awready}, 32'd0);
    chk("rst_wready", {31'd0, s_axi_wready}, 32'd0);
    chk("rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
    chk("rst_arready", {31'd0, s_axi_arready}, 32'd0);
    chk("rst_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
    chk("rst_rlast", {31'd0, s_axi_rlast}, 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    chk("rst_ids_resps", {20'd0, s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single beat write then read back
    wbuf[0] = 32'hDEADBEEF;
    push_b(4'd1, 2'b00);
    do_write(32'h10, 0, 4'd1, 4'hF, 1'b0);
    wait_idle();
    push_r(4'd3, 32'hDEADBEEF, 1'b1, 2'b00);
    do_read(32'h10, 0, 4'd3);
    wait_idle();

    // 16-beat INCR burst, back-to-back read
    for (int i = 0; i < 16; i++) wbuf[i] = i;
    push_b(4'd2, 2'b00);
    do_write(32'h100, 15, 4'd2, 4'hF, 1'b0);
    wait_idle();
    for (int i = 0; i < 16; i++) push_r(4'd4, i, i == 15, 2'b00);
    do_read(32'h100, 15, 4'd4);
    wait_idle();

    // byte strobes
    wbuf[0] = 32'hFFFFFFFF;
    push_b(4'd7, 2'b00);
    do_write(32'h20, 0, 4'd7, 4'hF, 1'b0);
    wbuf[0] = 32'h12345678;
    push_b(4'd8, 2'b00);
    do_write(32'h20, 0, 4'd8, 4'h3, 1'b0);
    wait_idle();
    push_r(4'd9, 32'hFFFF5678, 1'b1, 2'b00);
    do_read(32'h20, 0, 4'd9);
    wait_idle();

    // read with rready toggling, then B back-pressure
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hA5A50000 + i;
    push_b(4'd10, 2'b00);
    do_write(32'h200, 7, 4'd10, 4'hF, 1'b0);
    wait_idle();
    for (int i = 0; i < 8; i++) push_r(4'd11, 32'hA5A50000 + i, i == 7, 2'b00);
    rtoggle = 1'b1;
    do_read(32'h200, 7, 4'd11);
    wait_idle();
    rtoggle = 1'b0;
    s_axi_bready = 1'b0;
    wbuf[0] = 32'h0BADF00D;
    push_b(4'd12, 2'b00);
    do_write(32'h300, 0, 4'd12, 4'hF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("b_held_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
      chk("b_held_awready", {31'd0, s_axi_awready}, 32'd0);
    end
    @(posedge clk); #1;
    s_axi_bready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("awready_after_b", {31'd0, s_axi_awready}, 32'd1);
    wait_idle();

    // simultaneous AW/AR to the same words: read sees pre-write data
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h11110000 + i;
    push_b(4'd1, 2'b00);
    do_write(32'h40, 3, 4'd1, 4'hF, 1'b0);
    wait_idle();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h22220000 + i;
    push_b(4'd2, 2'b00);
    for (int i = 0; i < 4; i++) push_r(4'd3, 32'h11110000 + i, i == 3, 2'b00);
    fork
      do_write(32'h40, 3, 4'd2, 4'hF, 1'b0);
      do_read(32'h40, 3, 4'd3);
    join
    wait_idle();
    for (int i = 0; i < 4; i++) push_r(4'd4, 32'h22220000 + i, i == 3, 2'b00);
    do_read(32'h40, 3, 4'd4);
    wait_idle();

    // out-of-range address and misplaced wlast
    wbuf[0] = 32'hCAFE0000;
    push_b(4'd5, 2'b00);
    do_write(32'h0, 0, 4'd5, 4'hF, 1'b0);
    wait_idle();
    wbuf[0] = 32'h55550001;
    wbuf[1] = 32'h55550002;
`ifdef AXI_SLV_ERRCHK_EN
    push_r(4'd5, 32'hDEADDEAD, 1'b1, 2'b10);
    do_read(32'h4000, 0, 4'd5);
    wait_idle();
    push_r(4'd6, 32'hDEADDEAD, 1'b0, 2'b10);
    push_r(4'd6, 32'hDEADDEAD, 1'b1, 2'b10);
    do_read(32'h3FFC, 1, 4'd6);
    wait_idle();
    push_b(4'd6, 2'b10);
`else
    push_r(4'd5, 32'hCAFE0000, 1'b1, 2'b00);
    do_read(32'h4000, 0, 4'd5);
    wait_idle();
    push_b(4'd6, 2'b00);
`endif
    do_write(32'h500, 1, 4'd6, 4'hF, 1'b1);
    wait_idle();
    push_r(4'd7, 32'h55550001, 1'b0, 2'b00);
    push_r(4'd7, 32'h55550002, 1'b1, 2'b00);
    do_read(32'h500, 1, 4'd7);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end
endmodule
